// File: rtl/bp_reg_initiator.sv
// BytePipe command initiator: the requesting end of the register-map protocol.
// Serialises one request (write, single read, burst read) into command bytes,
// forwards the responder's reply bytes to the response port, and aborts with a
// sticky timeout flag if the responder stops replying.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_*/o_req_ready          request: wr, addr[6:0], data[7:0], len[7:0]
//   o_rsp_*/i_rsp_ready          forwarded reply bytes, o_rsp_last on final byte
//   o_timeout                    sticky abort flag, cleared on next request accept
//   o_bp_data/valid, i_bp_ready  command bytes towards the responder
//   i_bp_data/valid, o_bp_ready  reply bytes from the responder
module bp_reg_initiator #(
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_wr,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_data,
  input  logic [7:0] i_req_len,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic       o_rsp_last,
  output logic       o_timeout,
  output logic [7:0] o_bp_data,
  output logic       o_bp_valid,
  input  logic       i_bp_ready,
  input  logic [7:0] i_bp_data,
  input  logic       i_bp_valid,
  output logic       o_bp_ready
);

  typedef enum logic [2:0] {
    StIdle, StBCmd, StBLen, StBDrop, StCmd, StWData, StRx
  } state_e;

  state_e stateQ, stateD;

  // Captured request fields; deliberately left without reset.
  logic       wrQ;
  logic [6:0] addrQ;
  logic [7:0] dataQ;
  logic [7:0] lenQ;

  logic [7:0]           remQ, remD;
  logic [TIMEOUT_W-1:0] toCntQ, toCntD;
  logic                 timeoutQ, timeoutD;

  logic reqAccept;
  logic cmdFire;
  logic rplFire;
  logic waiting;
  logic toHit;

  assign o_req_ready = (stateQ == StIdle);
  assign reqAccept   = i_req_valid && o_req_ready;

  // Command byte mux; data stays stable because it only depends on state and captured fields.
  always_comb begin
    o_bp_valid = 1'b0;
    o_bp_data  = 8'h00;
    unique case (stateQ)
      StBCmd: begin
        o_bp_valid = 1'b1;
        o_bp_data  = 8'h80;
      end
      StBLen: begin
        o_bp_valid = 1'b1;
        o_bp_data  = lenQ;
      end
      StCmd: begin
        o_bp_valid = 1'b1;
        o_bp_data  = {wrQ, addrQ};
      end
      StWData: begin
        o_bp_valid = 1'b1;
        o_bp_data  = dataQ;
      end
      default: ;
    endcase
  end

  // Responder gates its command ready on o_bp_ready, so it must be high in every busy state.
  assign o_bp_ready  = (stateQ == StRx) ? i_rsp_ready : (stateQ != StIdle);
  assign o_rsp_valid = (stateQ == StRx) && i_bp_valid;
  assign o_rsp_data  = i_bp_data;
  assign o_rsp_last  = o_rsp_valid && (remQ == 8'd0);
  assign o_timeout   = timeoutQ;

  assign cmdFire = o_bp_valid && i_bp_ready;
  assign rplFire = i_bp_valid && o_bp_ready;
  assign waiting = (stateQ == StBDrop) || (stateQ == StRx);
  // Only responder silence counts; a valid byte stalled by the sink does not.
  assign toHit   = waiting && !i_bp_valid &&
                   (toCntQ == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stateD   = stateQ;
    remD     = remQ;
    timeoutD = timeoutQ;
    toCntD   = toCntQ;

    if (!waiting || rplFire) begin
      toCntD = '0;
    end else if (!i_bp_valid && (toCntQ != '1)) begin
      toCntD = toCntQ + 1'b1;
    end

    unique case (stateQ)
      StIdle: begin
        if (reqAccept) begin
          timeoutD = 1'b0;
          stateD   = (!i_req_wr && (i_req_len != 8'd0)) ? StBCmd : StCmd;
        end
      end
      StBCmd: if (cmdFire) stateD = StBLen;
      StBLen: if (cmdFire) stateD = StBDrop;
      StBDrop: begin
        // Reply to the burst-arm write is swallowed here.
        if (rplFire) begin
          stateD = StCmd;
        end else if (toHit) begin
          stateD   = StIdle;
          timeoutD = 1'b1;
        end
      end
      StCmd: begin
        if (cmdFire) begin
          if (wrQ) begin
            stateD = StWData;
          end else begin
            stateD = StRx;
            remD   = lenQ;
          end
        end
      end
      StWData: begin
        if (cmdFire) begin
          stateD = StRx;
          remD   = 8'd0;
        end
      end
      StRx: begin
        if (rplFire) begin
          if (remQ == 8'd0) stateD = StIdle;
          else              remD   = remQ - 8'd1;
        end else if (toHit) begin
          stateD   = StIdle;
          timeoutD = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stateQ   <= StIdle;
      remQ     <= 8'd0;
      toCntQ   <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      remQ     <= remD;
      toCntQ   <= toCntD;
      timeoutQ <= timeoutD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reqAccept) begin
      wrQ   <= i_req_wr;
      addrQ <= i_req_addr;
      dataQ <= i_req_data;
      lenQ  <= i_req_len;
    end
  end

endmodule

// File: tb/tb_bp_reg_initiator.sv
module tb_bp_reg_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       reqValid;
  logic       reqReady;
  logic       reqWr;
  logic [6:0] reqAddr;
  logic [7:0] reqData;
  logic [7:0] reqLen;
  logic [7:0] rspData;
  logic       rspValid;
  logic       rspReady;
  logic       rspLast;
  logic       timeout;
  logic [7:0] cmdData;
  logic       cmdValid;
  logic       cmdReady;
  logic [7:0] rplData;
  logic       rplValid;
  logic       rplReady;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_reg_initiator #(
    .TIMEOUT_W      (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_wr    (reqWr),
    .i_req_addr  (reqAddr),
    .i_req_data  (reqData),
    .i_req_len   (reqLen),
    .o_rsp_data  (rspData),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_last  (rspLast),
    .o_timeout   (timeout),
    .o_bp_data   (cmdData),
    .o_bp_valid  (cmdValid),
    .i_bp_ready  (cmdReady),
    .i_bp_data   (rplData),
    .i_bp_valid  (rplValid),
    .o_bp_ready  (rplReady)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request end to end. The bench plays the responder: the expected command bytes and
  // reply counts come straight from the protocol rules (burst = 80,len,drop-reply,cmd).
  // rdyMode: 0 sink always ready, 1 toggling, 2 random. silent: responder never replies.
  task automatic runReq(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                        input logic [7:0] len, input int rdyMode, input int maxGap,
                        input bit silent, input bit fixedEn, input logic [7:0] fixedByte);
    logic [7:0] expCmd[$];
    logic [7:0] expRsp[$];
    logic [7:0] rxQ[$];
    int  nCmd, nRsp, gap, idleCnt, nExp;
    bit  presenting, burst, done;
    burst = !wr && (len != 8'd0);
    if (burst)   expCmd = '{8'h80, len, {1'b0, addr}};
    else if (wr) expCmd = '{{1'b1, addr}, data};
    else         expCmd = '{{1'b0, addr}};
    nExp = wr ? 1 : int'(len) + 1;
    for (int i = 0; i < nExp; i++)
      expRsp.push_back((fixedEn && i == 0) ? fixedByte : 8'($urandom));

    @(negedge clk);
    reqValid = 1'b1;
    reqWr    = wr;
    reqAddr  = addr;
    reqData  = data;
    reqLen   = len;
    #1;
    check("reqReadyIdle", {31'd0, reqReady}, 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWr    = 1'($urandom);
    reqData  = 8'($urandom);
    check("timeoutClrOnAccept", {31'd0, timeout}, 32'd0);

    nCmd = 0; nRsp = 0; idleCnt = 0; presenting = 0; done = 0;
    gap = $urandom_range(0, maxGap);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      cmdReady = ($urandom_range(0, 3) != 0);
      case (rdyMode)
        0:       rspReady = 1'b1;
        1:       rspReady = cyc[0];
        default: rspReady = ($urandom_range(0, 2) != 0);
      endcase
      if (!presenting && rxQ.size() > 0) begin
        if (gap == 0) presenting = 1;
        else gap--;
      end
      rplValid = presenting;
      rplData  = presenting ? rxQ[0] : 8'($urandom);
      #1;
      if (reqReady) begin
        done = 1;
        break;
      end
      if (nCmd == expCmd.size()) idleCnt++;
      if (cmdValid) begin
        check("bpReadyBusy", {31'd0, rplReady}, 32'd1);
        if (nCmd < expCmd.size()) check("cmdByte", {24'd0, cmdData}, {24'd0, expCmd[nCmd]});
        else check("cmdExtra", 32'd1, 32'd0);
        if (cmdReady) begin
          nCmd++;
          if (burst && nCmd == 2) rxQ.push_back(8'($urandom));
          if (nCmd == expCmd.size() && !silent)
            foreach (expRsp[i]) rxQ.push_back(expRsp[i]);
        end
      end
      if (rplValid && rplReady) begin
        if (rspValid) begin
          if (nRsp < expRsp.size()) begin
            check("rspData", {24'd0, rspData}, {24'd0, expRsp[nRsp]});
            check("rspLast", {31'd0, rspLast}, {31'd0, nRsp == expRsp.size() - 1});
          end else begin
            check("rspExtra", 32'd1, 32'd0);
          end
          nRsp++;
        end
        void'(rxQ.pop_front());
        presenting = 0;
        gap = $urandom_range(0, maxGap);
      end
    end
    rplValid = 1'b0;
    check("reqDone", {31'd0, done}, 32'd1);
    check("cmdCount", nCmd, expCmd.size());
    check("rspCount", nRsp, silent ? 0 : expRsp.size());
    check("timeoutFlag", {31'd0, timeout}, {31'd0, silent});
    if (silent) check("timeoutIdleCycles", idleCnt, 4);
  endtask

  initial begin
    rst      = 1'b1;
    reqValid = 1'b0;
    reqWr    = 1'b0;
    reqAddr  = 7'd0;
    reqData  = 8'd0;
    reqLen   = 8'd0;
    rspReady = 1'b1;
    cmdReady = 1'b0;
    rplData  = 8'd0;
    rplValid = 1'b0;
    #2;
    check("rstReqReady", {31'd0, reqReady}, 32'd1);
    check("rstBpValid", {31'd0, cmdValid}, 32'd0);
    check("rstRspValid", {31'd0, rspValid}, 32'd0);
    check("rstRspLast", {31'd0, rspLast}, 32'd0);
    check("rstBpReady", {31'd0, rplReady}, 32'd0);
    check("rstTimeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write addr 9 data 05: bytes 89,05 and one forwarded reply with last.
    runReq(1'b1, 7'd9, 8'h05, 8'h00, 0, 1, 0, 0, 8'h00);
    // Single read addr 14, reply A5.
    runReq(1'b0, 7'd14, 8'h00, 8'h00, 0, 1, 0, 1, 8'hA5);
    // Burst read addr 1 len 3: 80,03, drop one, 01, four replies.
    runReq(1'b0, 7'd1, 8'h00, 8'h03, 0, 2, 0, 0, 8'h00);
    // Burst with toggling sink and back-to-back replies: stalls must not time out.
    runReq(1'b0, 7'd33, 8'h00, 8'h07, 1, 0, 0, 0, 8'h00);
    // Silent responder after read command.
    runReq(1'b0, 7'd20, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    check("timeoutSticky", {31'd0, timeout}, 32'd1);
    runReq(1'b1, 7'd0, 8'h02, 8'h55, 2, 2, 0, 0, 8'h00);

    // Reset in the middle of a burst while the length byte is waiting.
    @(negedge clk);
    cmdReady = 1'b0;
    reqValid = 1'b1;
    reqWr    = 1'b0;
    reqAddr  = 7'd5;
    reqLen   = 8'h06;
    @(negedge clk);
    reqValid = 1'b0;
    #1;
    check("midBurstCmd80", {24'd0, cmdData}, 32'h80);
    cmdReady = 1'b1;
    @(negedge clk);
    cmdReady = 1'b0;
    #1;
    check("midBurstLen", {24'd0, cmdData}, 32'h06);
    rst = 1'b1;
    #1;
    check("rstMidBpValid", {31'd0, cmdValid}, 32'd0);
    check("rstMidReqReady", {31'd0, reqReady}, 32'd1);
    @(negedge clk);
    #1;
    check("rstHeldBpReady", {31'd0, rplReady}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runReq(1'b0, 7'd77, 8'h00, 8'h00, 0, 1, 0, 1, 8'h3C);

    // Randomized traffic against the protocol model.
    for (int n = 0; n < 30; n++) begin
      logic       w;
      logic [6:0] a;
      w = 1'($urandom);
      a = 7'($urandom_range(1, 127));
      runReq(w, a, 8'($urandom), 8'($urandom_range(0, 5)), 2, 2, 0, 0, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
